alu_arbiter: RTL and testbench

Shares one 32-bit `ALU` instance between two requesters, e.g. the main datapath and a multi-cycle helper unit. Each requester has its own valid/ready request channel and valid/ready response channel. The block grants the ALU to one requester, registers the operands that drive `ALU`, captures `r`/`zero`/`overflow`, and returns them to the requester that was granted. It sits between the requesters and the `ALU` instance and owns that instance's `a`, `b` and `s` inputs.

---
 rtl/alu_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit ALU between two valid/ready requesters.
// Ports: clk, rst (async, active-high); req0_*/req1_* request channels
// (valid, ready, a, b, s); rsp0_*/rsp1_* response handshakes with shared
// rsp_r/rsp_zero/rsp_ovf; alu_a/alu_b/alu_s to the ALU, alu_r/alu_zero/
// alu_ovf back from it.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins
// ties, port 1 may starve); default is round-robin on the last completer.
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [3:0]   req0_s,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req1_s,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp_r,
  output logic         rsp_zero,
  output logic         rsp_ovf,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_s,
  input  logic [W-1:0] alu_r,
  input  logic         alu_zero,
  input  logic         alu_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  logic         phase;
  logic         owner;
  logic         grant;
  logic         take;
  logic         rsp_hit;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   op_s;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic         last;
`endif

  // ALU operands come only from registers, never from req* inputs.
  assign alu_a = op_a;
  assign alu_b = op_b;
  assign alu_s = op_s;

  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant = ~req0_valid;
`else
    // On a tie the port that did not complete last wins.
    if (req0_valid && req1_valid)
      grant = ~last;
    else
      grant = req1_valid;
`endif
  end

  assign take = (state == IDLE) & (req0_valid | req1_valid);

  assign req0_ready = ~rst & take & req0_valid & ~grant;
  assign req1_ready = ~rst & take & req1_valid & grant;

  assign rsp0_valid = (state == RESP) & ~owner;
  assign rsp1_valid = (state == RESP) & owner;

  assign rsp_hit = owner ? rsp1_ready : rsp0_ready;

  // EXEC lasts two cycles: the first lets the freshly registered
  // operands settle through the ALU, the second ends with the capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= 1'b0;
      owner    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last     <= 1'b1;
`endif
      op_a     <= '0;
      op_b     <= '0;
      op_s     <= '0;
      rsp_r    <= '0;
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            owner <= grant;
            op_a  <= grant ? req1_a : req0_a;
            op_b  <= grant ? req1_b : req0_b;
            op_s  <= grant ? req1_s : req0_s;
            phase <= 1'b0;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (phase) begin
            rsp_r    <= alu_r;
            rsp_zero <= alu_zero;
            rsp_ovf  <= alu_ovf;
            phase    <= 1'b0;
            state    <= RESP;
          end else begin
            phase <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_hit) begin
`ifndef ALU_ARB_FIXED_PRIO_EN
            last  <= owner;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter with a
// behavioural ALU attached and a service-order/result reference model.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic [3:0]   req0_s;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic [3:0]   req1_s;
  logic         rsp0_valid, rsp0_ready;
  logic         rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_r;
  logic         rsp_zero, rsp_ovf;
  logic [W-1:0] alu_a, alu_b, alu_r;
  logic [3:0]   alu_s;
  logic         alu_zero, alu_ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_r(rsp_r), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_ovf(alu_ovf)
  );

  // Behavioural ALU: returns {zero, overflow, r}.
  function automatic logic [W+1:0] alu_fn(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [3:0] s);
    logic [W-1:0] r;
    logic o;
    o = 1'b0;
    case (s)
      4'b0000, 4'b0010: begin
        r = a + b;
        o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0001, 4'b0011: begin
        r = a - b;
        o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~(a | b);
      4'b1000, 4'b1001: r = {b[15:0], 16'h0};
      4'b1010: r = (a < b) ? 1 : 0;
      4'b1011: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1100: r = $signed(b) >>> a[4:0];
      4'b1101: r = b >> a[4:0];
      default: r = b << a[4:0];
    endcase
    return {(r == 0), o, r};
  endfunction

  always_comb {alu_zero, alu_ovf, alu_r} = alu_fn(alu_a, alu_b, alu_s);

  task automatic set_req(input int p, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] s);
    if (p == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_s = s;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_s = s;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One request on port p, response held off for 'hold' cycles.
  task automatic run_single(input int p, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [3:0] s,
                            input logic [W-1:0] er, input logic ez,
                            input logic eo, input int hold,
                            input string tag);
    int cnt;
    logic got, v, ov;
    @(negedge clk);
    set_req(p, 1'b1, a, b, s);
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 50) begin
      #1;
      got = (p == 0) ? req0_ready : req1_ready;
      if (!got) begin
        @(negedge clk);
        cnt++;
      end
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s accept: ready=0 required 1", tag);
      set_req(p, 1'b0, '0, '0, '0);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    set_req(p, 1'b0, '0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      v  = (p == 0) ? rsp0_valid : rsp1_valid;
      ov = (p == 0) ? rsp1_valid : rsp0_valid;
      n_cmp++;
      if (v !== (c == 2)) begin
        n_err++;
        $display("FAIL %s latency c=%0d: valid=%b required %b",
                 tag, c, v, (c == 2));
      end
      n_cmp++;
      if (ov !== 1'b0) begin
        n_err++;
        $display("FAIL %s other valid c=%0d: got %b required 0",
                 tag, c, ov);
      end
      if (c < 2) @(negedge clk);
    end
    n_cmp++;
    if ({rsp_zero, rsp_ovf, rsp_r} !== {ez, eo, er}) begin
      n_err++;
      $display("FAIL %s result: z/o/r=%b/%b/%h required %b/%b/%h",
               tag, rsp_zero, rsp_ovf, rsp_r, ez, eo, er);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      v = (p == 0) ? rsp0_valid : rsp1_valid;
      n_cmp++;
      if ({v, rsp_r} !== {1'b1, er}) begin
        n_err++;
        $display("FAIL %s hold %0d: valid/r=%b/%h required 1/%h",
                 tag, h, v, rsp_r, er);
      end
    end
    if (p == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    n_cmp++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL %s release: valids=%b%b required 00",
               tag, rsp0_valid, rsp1_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid,
         rsp_zero, rsp_ovf} !== 6'b0) begin
      n_err++;
      $display("FAIL reset flags: %b%b%b%b%b%b required 000000",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp_zero, rsp_ovf);
    end
    n_cmp++;
    if ({rsp_r, alu_a, alu_b, alu_s} !== '0) begin
      n_err++;
      $display("FAIL reset data: r=%h a=%h b=%h s=%h required 0",
               rsp_r, alu_a, alu_b, alu_s);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_single(0, 32'h7FFF_FFFF, 32'h1, 4'b0010,
               32'h8000_0000, 1'b0, 1'b1, 0, "add_ovf");
    run_single(1, 32'd5, 32'd5, 4'b0001, 32'h0, 1'b1, 1'b0, 0, "sub_zero");
    run_single(1, 32'hFFFF_FFFF, 32'h1, 4'b1011,
               32'h1, 1'b0, 1'b0, 1, "slt");
    run_single(0, 32'd4, 32'h8000_0000, 4'b1100,
               32'hF800_0000, 1'b0, 1'b0, 0, "sra");
    run_single(0, 32'd4, 32'h8000_0000, 4'b1101,
               32'h0800_0000, 1'b0, 1'b0, 2, "srl");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [3:0] s;
    logic [W+1:0] e;
    for (int i = 0; i < 24; i++) begin
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      s = 4'($urandom_range(0, 15));
      e = alu_fn(a, b, s);
      run_single(int'($urandom_range(0, 1)), a, b, s, e[W-1:0], e[W+1],
                 e[W], int'($urandom_range(0, 3)), "random");
    end
  endtask

  logic [W-1:0] ra [8];
  logic [W-1:0] rb [8];
  logic [3:0]   rs [8];
  int           comp_port[$];
  logic [W-1:0] comp_r[$];
  time          acc_t[$];
  int           drv_err = 0;

  task automatic drive_port(input int p);
    int cnt;
    logic got;
    for (int i = 0; i < 4; i++) begin
      set_req(p, 1'b1, ra[p*4+i], rb[p*4+i], rs[p*4+i]);
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 100) begin
        #1;
        got = (p == 0) ? req0_ready : req1_ready;
        if (!got) begin
          @(negedge clk);
          cnt++;
        end
      end
      if (!got) begin
        drv_err++;
        break;
      end
      @(posedge clk);
      acc_t.push_back($time);
      @(negedge clk);
    end
    set_req(p, 1'b0, '0, '0, '0);
  endtask

  task automatic monitor_rsp();
    for (int c = 0; c < 200 && comp_port.size() < 8; c++) begin
      @(negedge clk);
      if (rsp0_valid) begin
        comp_port.push_back(0);
        comp_r.push_back(rsp_r);
      end
      if (rsp1_valid) begin
        comp_port.push_back(1);
        comp_r.push_back(rsp_r);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_port[8];
    logic [W-1:0] exp_r[8];
    logic [W+1:0] e;
    int n0, n1, lst, pick;
    for (int i = 0; i < 8; i++) begin
      ra[i] = $urandom();
      rb[i] = $urandom();
      rs[i] = 4'($urandom_range(0, 15));
    end
    // Reference service order from the arbitration rule.
    n0 = 0; n1 = 0; lst = 1;
    for (int k = 0; k < 8; k++) begin
      if (n0 < 4 && n1 < 4) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        pick = 0;
`else
        pick = 1 - lst;
`endif
      end else begin
        pick = (n0 < 4) ? 0 : 1;
      end
      if (pick == 0) begin
        e = alu_fn(ra[n0], rb[n0], rs[n0]);
        n0++;
      end else begin
        e = alu_fn(ra[4+n1], rb[4+n1], rs[4+n1]);
        n1++;
      end
      exp_port[k] = pick;
      exp_r[k] = e[W-1:0];
      lst = pick;
    end
    comp_port.delete();
    comp_r.delete();
    acc_t.delete();
    drv_err = 0;
    @(negedge clk);
    rst = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fork
      drive_port(0);
      drive_port(1);
      monitor_rsp();
    join
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    n_cmp++;
    if (drv_err != 0 || comp_port.size() != 8) begin
      n_err++;
      $display("FAIL rr count: stalls=%0d responses=%0d required 0/8",
               drv_err, comp_port.size());
    end
    for (int k = 0; k < 8 && k < comp_port.size(); k++) begin
      n_cmp++;
      if (comp_port[k] != exp_port[k] || comp_r[k] !== exp_r[k]) begin
        n_err++;
        $display("FAIL rr op %0d: port/r=%0d/%h required %0d/%h",
                 k, comp_port[k], comp_r[k], exp_port[k], exp_r[k]);
      end
    end
    for (int k = 1; k < acc_t.size(); k++) begin
      n_cmp++;
      if (acc_t[k] - acc_t[k-1] != 40) begin
        n_err++;
        $display("FAIL rr spacing %0d: %0t required 40",
                 k, acc_t[k] - acc_t[k-1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int cnt;
    do_reset();
    set_req(0, 1'b1, 32'h0000_F000, 32'h0000_0FF0, 4'b0101);
    set_req(1, 1'b1, 32'd1, 32'd2, 4'b0000);
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL bp tie: ready=%b%b required 10",
               req0_ready, req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    for (int h = 0; h < 5; h++) begin
      n_cmp++;
      if ({rsp0_valid, rsp1_valid, req1_ready, rsp_r} !==
          {3'b100, 32'h0000_FFF0}) begin
        n_err++;
        $display("FAIL bp hold %0d: v0/v1/rdy1/r=%b/%b/%b/%h required 1/0/0/0000fff0",
                 h, rsp0_valid, rsp1_valid, req1_ready, rsp_r);
      end
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    #1;
    n_cmp++;
    if (req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp hs: req1_ready=%b required 0", req1_ready);
    end
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp after: req1_ready=%b required 1", req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    set_req(1, 1'b0, '0, '0, '0);
    cnt = 0;
    while (!rsp1_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if ({rsp1_valid, rsp_r} !== {1'b1, 32'd3}) begin
      n_err++;
      $display("FAIL bp port1: valid/r=%b/%h required 1/00000003",
               rsp1_valid, rsp_r);
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_req(0, 1'b1, 32'd10, 32'd20, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({alu_a, alu_b, alu_s, rsp_r, rsp_zero, rsp_ovf, rsp0_valid,
         rsp1_valid, req0_ready, req1_ready} !== '0) begin
      n_err++;
      $display("FAIL mid reset: a=%h b=%h s=%h r=%h v=%b%b required 0",
               alu_a, alu_b, alu_s, rsp_r, rsp0_valid, rsp1_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    run_single(1, 32'd3, 32'd2, 4'b0000, 32'd5, 1'b0, 1'b0, 0,
               "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
